// File: rtl/vu_level_detector.sv
// Stereo VU level detector: |sample| peak capture, optional peak hold, linear decay, sticky clip flags.
// Latency: a sample strobe reaches the level/clip outputs after 3 clk edges; clip_clr acts on the next edge.
// Backpressure: none; strobes are fire-and-forget and must be at least 3 clk apart. Hold stage via VU_PEAK_HOLD_EN.
module vu_level_detector #(
  parameter int SAMPLE_W      = 24,
  parameter int HOLD_SAMPLES  = 9600,
  parameter int DECAY_SAMPLES = 384
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                audio_clk_enable,
  input  logic                audio_enable,
  input  logic [SAMPLE_W-1:0] l_sample,
  input  logic [SAMPLE_W-1:0] r_sample,
  input  logic                clip_clr,
  output logic [7:0]          l_audio_signal,
  output logic [7:0]          r_audio_signal,
  output logic                l_clip,
  output logic                r_clip
);

  // Elaboration-time parameter sanity checks.
  if (SAMPLE_W < 9) begin : g_bad_sample_w
    $error("vu_level_detector: SAMPLE_W must be >= 9");
  end
  if (HOLD_SAMPLES < 1) begin : g_bad_hold
    $error("vu_level_detector: HOLD_SAMPLES must be >= 1");
  end
  if (DECAY_SAMPLES < 1) begin : g_bad_decay
    $error("vu_level_detector: DECAY_SAMPLES must be >= 1");
  end

  localparam int DECAY_W = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;
  localparam logic [DECAY_W-1:0] DECAY_RELOAD = DECAY_W'(DECAY_SAMPLES - 1);
`ifdef VU_PEAK_HOLD_EN
  localparam int HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_SAMPLES - 1);
`endif

  localparam logic [SAMPLE_W-2:0] MAG_MAX = '1;
  localparam logic [SAMPLE_W-2:0] MAG_ONE = {{(SAMPLE_W-2){1'b0}}, 1'b1};

`ifdef VU_PEAK_HOLD_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_DECAY} state_t;
`else
  typedef enum logic {ST_IDLE, ST_DECAY} state_t;
`endif

  logic                tick1;
  logic                tick2;
  logic [SAMPLE_W-1:0] smp_q [2];
  logic [1:0][7:0]     level_bus;
  logic [1:0]          clip_bus;

  // Stage 1: capture both samples on the strobe and launch the tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick1    <= 1'b0;
      smp_q[0] <= '0;
      smp_q[1] <= '0;
    end else begin
      tick1 <= audio_clk_enable;
      if (audio_clk_enable) begin
        smp_q[0] <= l_sample;
        smp_q[1] <= r_sample;
      end
    end
  end

  // Tick delayed to line up with the registered magnitude.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick2 <= 1'b0;
    end else begin
      tick2 <= tick1;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [SAMPLE_W-2:0] mag;
    logic [7:0]          mag8_q;
    logic                clip_hit_q;
    state_t              state_q, state_d;
    logic [7:0]          level_q, level_d;
    logic [DECAY_W-1:0]  decay_q, decay_d;
`ifdef VU_PEAK_HOLD_EN
    logic [HOLD_W-1:0]   hold_q, hold_d;
`endif
    logic                clip_q;

    // Absolute value; the most negative code saturates to full scale.
    always_comb begin
      mag = smp_q[ch][SAMPLE_W-2:0];
      if (smp_q[ch][SAMPLE_W-1]) begin
        if (smp_q[ch][SAMPLE_W-2:0] == '0) begin
          mag = MAG_MAX;
        end else begin
          mag = ~smp_q[ch][SAMPLE_W-2:0] + MAG_ONE;
        end
      end
    end

    // Stage 2: register the 8-bit meter magnitude and the full-scale hit.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        mag8_q     <= '0;
        clip_hit_q <= 1'b0;
      end else if (tick1) begin
        mag8_q     <= mag[SAMPLE_W-2 -: 8];
        clip_hit_q <= (mag == MAG_MAX);
      end
    end

    // Stage 3 next-state: peak capture, hold and linear decay ballistics.
    always_comb begin
      state_d = state_q;
      level_d = level_q;
      decay_d = decay_q;
`ifdef VU_PEAK_HOLD_EN
      hold_d  = hold_q;
`endif
      if (!audio_enable) begin
        state_d = ST_IDLE;
        level_d = '0;
        decay_d = '0;
`ifdef VU_PEAK_HOLD_EN
        hold_d  = '0;
`endif
      end else if (tick2) begin
        case (state_q)
          ST_IDLE: begin
            level_d = '0;
            if (mag8_q != 8'd0) begin
              level_d = mag8_q;
`ifdef VU_PEAK_HOLD_EN
              hold_d  = HOLD_RELOAD;
              state_d = ST_HOLD;
`else
              decay_d = DECAY_RELOAD;
              state_d = ST_DECAY;
`endif
            end
          end
`ifdef VU_PEAK_HOLD_EN
          ST_HOLD: begin
            if (mag8_q > level_q) begin
              level_d = mag8_q;
              hold_d  = HOLD_RELOAD;
            end else if (mag8_q == level_q) begin
              hold_d  = HOLD_RELOAD;
            end else if (hold_q == '0) begin
              decay_d = DECAY_RELOAD;
              state_d = ST_DECAY;
            end else begin
              hold_d  = hold_q - 1'b1;
            end
          end
`endif
          ST_DECAY: begin
            if ((mag8_q >= level_q) && (mag8_q != 8'd0)) begin
              level_d = mag8_q;
`ifdef VU_PEAK_HOLD_EN
              hold_d  = HOLD_RELOAD;
              state_d = ST_HOLD;
`else
              decay_d = DECAY_RELOAD;
`endif
            end else if (decay_q == '0) begin
              // Level is non-zero in DECAY, so this never wraps.
              level_d = level_q - 8'd1;
              decay_d = DECAY_RELOAD;
              if (level_q == 8'd1) begin
                state_d = ST_IDLE;
              end
            end else begin
              decay_d = decay_q - 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            level_d = '0;
          end
        endcase
      end
    end

    // Stage 3 state register; the level register drives the meter directly.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= ST_IDLE;
        level_q <= '0;
        decay_q <= '0;
`ifdef VU_PEAK_HOLD_EN
        hold_q  <= '0;
`endif
      end else begin
        state_q <= state_d;
        level_q <= level_d;
        decay_q <= decay_d;
`ifdef VU_PEAK_HOLD_EN
        hold_q  <= hold_d;
`endif
      end
    end

    // Sticky clip flag; a set on the same edge as a clear wins.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        clip_q <= 1'b0;
      end else if (tick2 && clip_hit_q) begin
        clip_q <= 1'b1;
      end else if (clip_clr) begin
        clip_q <= 1'b0;
      end
    end

    assign level_bus[ch] = level_q;
    assign clip_bus[ch]  = clip_q;
  end

  assign l_audio_signal = level_bus[0];
  assign r_audio_signal = level_bus[1];
  assign l_clip         = clip_bus[0];
  assign r_clip         = clip_bus[1];

endmodule

// File: tb/tb_vu_level_detector.sv
// Self-checking bench for vu_level_detector: reference ballistics model feeds an expected-value queue.
// Each strobe pushes the expected post-update levels/flags; they are popped 3 edges later.
// Strobes are issued every 10 clk; VU_PEAK_HOLD_EN selects the matching model behaviour.
module tb_vu_level_detector;

  localparam int SW      = 24;
  localparam int HOLD_N  = 4;
  localparam int DECAY_N = 2;
`ifdef VU_PEAK_HOLD_EN
  localparam int FE_TICK = 6;
`else
  localparam int FE_TICK = 2;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          audio_clk_enable = 1'b0;
  logic          audio_enable = 1'b1;
  logic [SW-1:0] l_sample = '0;
  logic [SW-1:0] r_sample = '0;
  logic          clip_clr = 1'b0;
  logic [7:0]    l_audio_signal;
  logic [7:0]    r_audio_signal;
  logic          l_clip;
  logic          r_clip;

  vu_level_detector #(
    .SAMPLE_W(SW), .HOLD_SAMPLES(HOLD_N), .DECAY_SAMPLES(DECAY_N)
  ) dut (
    .clk(clk), .reset(reset), .audio_clk_enable(audio_clk_enable),
    .audio_enable(audio_enable), .l_sample(l_sample), .r_sample(r_sample),
    .clip_clr(clip_clr), .l_audio_signal(l_audio_signal),
    .r_audio_signal(r_audio_signal), .l_clip(l_clip), .r_clip(r_clip)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] l;
    logic [7:0] r;
    logic       lc;
    logic       rc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state: 0 idle, 1 hold, 2 decay; th/td count ticks spent in hold/decay.
  int m_st[2];
  int m_lvl[2];
  int m_th[2];
  int m_td[2];
  bit m_clip[2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat_abs(input logic [SW-1:0] s);
    int v;
    v = $signed(s);
    if (v < 0) v = -v;
    if (v > 32'h7FFFFF) v = 32'h7FFFFF;
    return v;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_st[c] = 0; m_lvl[c] = 0; m_th[c] = 0; m_td[c] = 0; m_clip[c] = 1'b0;
    end
  endfunction

  function automatic void enter_peak(input int c, input int m8);
    m_lvl[c] = m8;
`ifdef VU_PEAK_HOLD_EN
    m_st[c] = 1; m_th[c] = 0;
`else
    m_st[c] = 2; m_td[c] = 0;
`endif
  endfunction

  function automatic void model_tick(input int c, input logic [SW-1:0] s);
    int v, m8;
    if (!audio_enable) return;
    v  = sat_abs(s);
    m8 = (v >> 15) & 8'hFF;
    if (v == 32'h7FFFFF) m_clip[c] = 1'b1;
    case (m_st[c])
      0: if (m8 > 0) enter_peak(c, m8);
      1: begin
        if (m8 >= m_lvl[c]) begin
          if (m8 > m_lvl[c]) m_lvl[c] = m8;
          m_th[c] = 0;
        end else begin
          m_th[c]++;
          if (m_th[c] == HOLD_N) begin m_st[c] = 2; m_td[c] = 0; end
        end
      end
      default: begin
        if (m8 >= m_lvl[c] && m8 > 0) begin
          enter_peak(c, m8);
        end else begin
          m_td[c]++;
          if (m_td[c] == DECAY_N) begin
            m_lvl[c]--; m_td[c] = 0;
            if (m_lvl[c] == 0) m_st[c] = 0;
          end
        end
      end
    endcase
  endfunction

  // One strobe: push expectation, check old level still present after 2 edges, pop after 3.
  task automatic do_tick(input logic [SW-1:0] ls, input logic [SW-1:0] rs, input bit clr_same);
    exp_t e;
    logic [7:0] pl, pr;
    @(posedge clk); #1;
    audio_clk_enable = 1'b1; l_sample = ls; r_sample = rs;
    pl = m_lvl[0][7:0]; pr = m_lvl[1][7:0];
    if (clr_same) begin m_clip[0] = 1'b0; m_clip[1] = 1'b0; end
    model_tick(0, ls);
    model_tick(1, rs);
    e.l = m_lvl[0][7:0]; e.r = m_lvl[1][7:0]; e.lc = m_clip[0]; e.rc = m_clip[1];
    sb.push_back(e);
    @(posedge clk); #1;
    audio_clk_enable = 1'b0; l_sample = '0; r_sample = '0;
    @(posedge clk); #1;
    chk("l_latency", l_audio_signal, pl);
    chk("r_latency", r_audio_signal, pr);
    if (clr_same) clip_clr = 1'b1;
    @(posedge clk); #1;
    clip_clr = 1'b0;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("sb_l_level", l_audio_signal, e.l);
      chk("sb_r_level", r_audio_signal, e.r);
      chk("sb_l_clip", {7'd0, l_clip}, {7'd0, e.lc});
      chk("sb_r_clip", {7'd0, r_clip}, {7'd0, e.rc});
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_l"}, l_audio_signal, 8'h00);
    chk({tag, "_r"}, r_audio_signal, 8'h00);
    chk({tag, "_lc"}, {7'd0, l_clip}, 8'h00);
    chk({tag, "_rc"}, {7'd0, r_clip}, 8'h00);
  endtask

  initial begin
    model_reset();
    #12;
    check_all_zero("reset");
    #10 reset = 1'b1;

    // Full-scale left step, then zeros through hold and complete decay.
    do_tick(24'h7FFFFF, 24'h000000, 1'b0);
    chk("fs_l", l_audio_signal, 8'hFF);
    chk("fs_lclip", {7'd0, l_clip}, 8'h01);
    chk("fs_r", r_audio_signal, 8'h00);
    for (int k = 1; k <= FE_TICK + 2 * 254; k++) begin
      do_tick(24'h000000, 24'h000000, 1'b0);
      if (k == FE_TICK - 1) chk("fs_still_ff", l_audio_signal, 8'hFF);
      if (k == FE_TICK) chk("fs_first_fe", l_audio_signal, 8'hFE);
      if (k == FE_TICK + 2) chk("fs_fd", l_audio_signal, 8'hFD);
    end
    chk("fs_decayed_l", l_audio_signal, 8'h00);
    chk("fs_decayed_r", r_audio_signal, 8'h00);
    do_tick(24'h000000, 24'h000000, 1'b0);
    chk("fs_idle_l", l_audio_signal, 8'h00);

    // Negative magnitudes on the right channel.
    do_tick(24'h000000, 24'hFF8000, 1'b0);
    chk("neg_small_r", r_audio_signal, 8'h01);
    do_tick(24'h000000, 24'h800000, 1'b0);
    chk("neg_sat_r", r_audio_signal, 8'hFF);
    chk("neg_sat_rclip", {7'd0, r_clip}, 8'h01);

    // audio_enable drop while left is at 0x80.
    do_tick(24'h400000, 24'h000000, 1'b0);
    chk("en_l80", l_audio_signal, 8'h80);
    @(posedge clk); #1;
    audio_enable = 1'b0;
    for (int c = 0; c < 2; c++) begin m_st[c] = 0; m_lvl[c] = 0; m_th[c] = 0; m_td[c] = 0; end
    @(posedge clk); #1;
    chk("en_drop_l", l_audio_signal, 8'h00);
    chk("en_drop_r", r_audio_signal, 8'h00);
    chk("en_keep_lclip", {7'd0, l_clip}, 8'h01);
    chk("en_keep_rclip", {7'd0, r_clip}, 8'h01);
    do_tick(24'h400000, 24'h400000, 1'b0);
    chk("en_ignored_l", l_audio_signal, 8'h00);
    @(posedge clk); #1;
    audio_enable = 1'b1;

    // Clip clear coincident with a clipping update, then a lone clear.
    do_tick(24'h7FFFFF, 24'h000000, 1'b1);
    chk("clr_same_lclip", {7'd0, l_clip}, 8'h01);
    chk("clr_same_rclip", {7'd0, r_clip}, 8'h00);
    @(posedge clk); #1;
    clip_clr = 1'b1;
    m_clip[0] = 1'b0; m_clip[1] = 1'b0;
    @(posedge clk); #1;
    clip_clr = 1'b0;
    chk("clr_alone_lclip", {7'd0, l_clip}, 8'h00);

    // Reset asserted mid-decay clears everything asynchronously.
    for (int k = 0; k < 6; k++) do_tick(24'h000000, 24'h000000, 1'b0);
    chk("pre_reset_decaying", l_audio_signal, (FE_TICK == 6) ? 8'hFE : 8'hFC);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    model_reset();
    #2 reset = 1'b1;
    do_tick(24'h000000, 24'h000000, 1'b0);
    chk("post_reset_l", l_audio_signal, 8'h00);

    // Retrigger: smaller peak in hold keeps level, larger peak in decay recaptures.
    do_tick(24'h400000, 24'h000000, 1'b0);
    chk("rt_capture", l_audio_signal, 8'h80);
    do_tick(24'h200000, 24'h000000, 1'b0);
    chk("rt_small", l_audio_signal, 8'h80);
    for (int k = 0; k < 4; k++) do_tick(24'h000000, 24'h000000, 1'b0);
    do_tick(24'h600000, 24'h000000, 1'b0);
    chk("rt_recapture", l_audio_signal, 8'hC0);
    for (int k = 1; k <= 6; k++) begin
      do_tick(24'h000000, 24'h000000, 1'b0);
      if (k == FE_TICK - 1) chk("rt_hold_c0", l_audio_signal, 8'hC0);
      if (k == FE_TICK) chk("rt_first_bf", l_audio_signal, 8'hBF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vu_level_detector.md
# vu_level_detector

Per-channel level detector that sits directly upstream of the front-panel VU meter driver. It converts signed stereo audio samples into the 8-bit left/right levels the meter PWM consumes. Each 96 kHz sample strobe updates the levels using peak-capture, optional hold, and linear-decay ballistics. It also raises sticky clip flags.

## Interface
Parameters:
- SAMPLE_W, 24: signed sample width; must be ≥ 9.
- HOLD_SAMPLES, 9600: sample ticks a new peak is held (100 ms at 96 kHz); must be ≥ 1.
- DECAY_SAMPLES, 384: sample ticks per 1-LSB level decrement; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- audio_clk_enable  in  1  one-clk 96 kHz sample strobe.
- audio_enable  in  1  high while music plays.
- l_sample  in  SAMPLE_W  signed left sample, valid while audio_clk_enable is high.
- r_sample  in  SAMPLE_W  signed right sample, valid while audio_clk_enable is high.
- clip_clr  in  1  one-clk pulse that clears both clip flags.
- l_audio_signal  out  8  left level, registered.
- r_audio_signal  out  8  right level, registered.
- l_clip  out  1  sticky left clip flag.
- r_clip  out  1  sticky right clip flag.

## Operation
- Channels are identical and independent; the text below describes one channel.
- **Stage 1 (capture):** when audio_clk_enable is high, register the sample and raise an internal tick.
- **Stage 2 (magnitude):**
  - mag = |sample|; the most negative code saturates to 2^(SAMPLE_W-1)-1.
  - mag8 = mag[SAMPLE_W-2 -: 8], the top 8 magnitude bits.
  - clip_hit = (mag == 2^(SAMPLE_W-1)-1).
- **Stage 3 (ballistics FSM),** evaluated only on delayed ticks:
  - IDLE: level = 0. If mag8 > 0: level ← mag8, hold_cnt ← HOLD_SAMPLES-1, go to HOLD.
  - HOLD: if mag8 > level: recapture and reload hold_cnt. Else if mag8 == level: reload hold_cnt only. Else if hold_cnt == 0: decay_cnt ← DECAY_SAMPLES-1, go to DECAY. Otherwise hold_cnt decrements.
  - DECAY:
    - mag8 ≥ level and mag8 > 0: recapture, go to HOLD.
    - decay_cnt == 0: level ← level-1, decay_cnt ← DECAY_SAMPLES-1. If the new level is 0, go to IDLE.
    - Otherwise decay_cnt decrements.
  - Level never wraps below 0 or above 255.
- **audio_enable low:** on the next clk, level ← 0, state ← IDLE, and counters are cleared. Ticks are ignored while audio_enable is low. Clip flags are unaffected.
- **Clip flag:** set on a tick with clip_hit. Cleared by clip_clr. If set and clear occur in the same cycle, set wins.
- **Reset:** l_audio_signal, r_audio_signal, l_clip, r_clip, all counters and the pipeline tick are 0; state = IDLE. Reset asserted mid-hold or mid-decay aborts immediately.

## Timing
- A strobe in cycle N updates the level outputs and clip flags at the clk edge ending cycle N+2; they are visible in cycle N+3. Latency is fixed at 3 clk edges.
- Strobes must be ≥ 3 clk cycles apart. Closer strobes are unsupported, and the bench does not generate them.
- Hold time = HOLD_SAMPLES ticks after the last capture or retrigger tick.
- The first decrement occurs DECAY_SAMPLES ticks after leaving HOLD.
- Full decay of 255 takes 255·DECAY_SAMPLES ticks.
- clip_clr takes effect on the next edge, with no pipeline delay.

## Configuration
- VU_PEAK_HOLD_EN:
  - Defined: HOLD state and hold_cnt exist as described above.
  - Undefined: HOLD and hold_cnt are removed. Every capture goes directly to DECAY with decay_cnt ← DECAY_SAMPLES-1. HOLD_SAMPLES is ignored.

## Test plan
Bench parameters: HOLD_SAMPLES=4, DECAY_SAMPLES=2, strobe every 10 clk, VU_PEAK_HOLD_EN defined unless stated otherwise.
- **Reset:** assert reset mid-decay → all outputs 0 immediately; after release, first strobe with 0x000000 → level stays 0.
- **Full-scale step:** l_sample=0x7FFFFF once, then zeros → l_audio_signal=0xFF at 3 edges after the strobe and l_clip=1.
  - Level holds 0xFF for 4 ticks.
  - 0xFE appears 2 ticks later, then decrements every 2 ticks; reaches 0 and IDLE after 510 further ticks.
  - r_audio_signal stays 0.
- **Negative saturation:** r_sample=0x800000 → r_audio_signal=0xFF and r_clip=1. r_sample=0xFF8000 (-32768) → r_audio_signal=0x01.
- **Retrigger:** 0x400000 (level 0x80), then 0x200000 during HOLD → level stays 0x80. A 0x600000 during DECAY → level 0xC0 and hold restarts for 4 ticks.
- **audio_enable drop:** drop audio_enable while level is 0x80 → both levels are 0 next clk; strobes are ignored until audio_enable returns; clip flags are retained.
- **Clip clear and hold build:**
  - clip_clr in the same cycle as a clipping tick's flag update → flag remains 1.
  - clip_clr alone → flag becomes 0 next edge.
  - With VU_PEAK_HOLD_EN undefined, the full-scale step decays to 0xFE 2 ticks after capture.
